// File: rtl/usr_pkg.sv
// Shared types for the usr_shift_engine block: command opcodes and FSM states.
package usr_pkg;

  typedef enum logic [2:0] {
    OP_NOP   = 3'b000,
    OP_SHL   = 3'b001,
    OP_SHR   = 3'b010,
    OP_ASR   = 3'b011,
    OP_ROL   = 3'b100,
    OP_ROR   = 3'b101,
    OP_LOAD  = 3'b110,
    OP_CLEAR = 3'b111
  } op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/usr_shift_engine_if.sv
// Command handshake bundle for usr_shift_engine: the requester drives the
// command fields and load data, the engine answers with cmd_ready.
interface usr_shift_engine_if #(
  parameter int WIDTH = 8,
  parameter int AMT_W = $clog2(WIDTH) + 1
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [AMT_W-1:0] cmd_amount;
  logic [WIDTH-1:0] parallelIn;

  modport master (output cmd_valid, output cmd_op, output cmd_amount,
                  output parallelIn, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_op, input cmd_amount,
                  input parallelIn, output cmd_ready);
endinterface

// File: rtl/usr_step.sv
// One single-bit shift/rotate step of the register, purely combinational.
// Rotate paths exist only when USR_SHIFT_ENGINE_ROTATE_EN is defined.
module usr_step
  import usr_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] reg_i,
  input  op_e              op_i,
  input  logic             serialIn_left_i,
  input  logic             serialIn_right_i,
  output logic [WIDTH-1:0] reg_o
);

  // Next register value for one step of the captured operation
  always_comb begin
    reg_o = reg_i;
    case (op_i)
      OP_SHL: reg_o = {reg_i[WIDTH-2:0], serialIn_right_i};
      OP_SHR: reg_o = {serialIn_left_i, reg_i[WIDTH-1:1]};
      OP_ASR: reg_o = {reg_i[WIDTH-1], reg_i[WIDTH-1:1]};
`ifdef USR_SHIFT_ENGINE_ROTATE_EN
      OP_ROL: reg_o = {reg_i[WIDTH-2:0], reg_i[WIDTH-1]};
      OP_ROR: reg_o = {reg_i[0], reg_i[WIDTH-1:1]};
`endif
      default: reg_o = reg_i;
    endcase
  end

endmodule

// File: rtl/usr_shift_engine.sv
// WIDTH-bit universal shift register with a command handshake. Shifts of N
// positions run one bit per clock in the RUN state; LOAD/CLEAR/NOP and
// zero-amount shifts finish at the accepting edge. done pulses one cycle
// after completion. Optional macro USR_SHIFT_ENGINE_ROTATE_EN enables
// ROL/ROR; without it those opcodes behave as NOP.
module usr_shift_engine
  import usr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int AMT_W = $clog2(WIDTH) + 1
) (
  input  logic               clk,
  input  logic               reset,
  usr_shift_engine_if.slave  cmd,
  input  logic               serialIn_left,
  input  logic               serialIn_right,
  output logic [WIDTH-1:0]   parallelOut,
  output logic               serialOut_msb,
  output logic               serialOut_lsb,
  output logic               busy,
  output logic               done
);

  state_e           state_q, state_d;
  logic [AMT_W-1:0] cnt_q, cnt_d;
  op_e              op_q, op_d;
  logic [WIDTH-1:0] reg_q, reg_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] step_val;
  op_e              cmd_op_e;
  logic             accept;

  assign cmd_op_e = op_e'(cmd.cmd_op);
  assign accept   = cmd.cmd_valid && (state_q == ST_IDLE);

  usr_step #(.WIDTH(WIDTH)) u_step (
    .reg_i            (reg_q),
    .op_i             (op_q),
    .serialIn_left_i  (serialIn_left),
    .serialIn_right_i (serialIn_right),
    .reg_o            (step_val)
  );

  // State, counter, captured opcode, data register and done flag
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= OP_NOP;
      reg_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      reg_q   <= reg_d;
      done_q  <= done_d;
    end
  end

  // Command decode in IDLE, one shift step per cycle in RUN
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    reg_d   = reg_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          case (cmd_op_e)
            OP_LOAD: begin
              reg_d  = cmd.parallelIn;
              done_d = 1'b1;
            end
            OP_CLEAR: begin
              reg_d  = '0;
              done_d = 1'b1;
            end
            OP_SHL, OP_SHR, OP_ASR
`ifdef USR_SHIFT_ENGINE_ROTATE_EN
            , OP_ROL, OP_ROR
`endif
            : begin
              if (cmd.cmd_amount != '0) begin
                state_d = ST_RUN;
                cnt_d   = cmd.cmd_amount;
                op_d    = cmd_op_e;
              end else begin
                done_d = 1'b1;
              end
            end
            default: done_d = 1'b1;
          endcase
        end
      end
      ST_RUN: begin
        reg_d = step_val;
        cnt_d = cnt_q - AMT_W'(1);
        if (cnt_q == AMT_W'(1)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy          = (state_q == ST_RUN);
  assign cmd.cmd_ready = !busy;
  assign done          = done_q;
  assign parallelOut   = reg_q;
  assign serialOut_msb = reg_q[WIDTH-1];
  assign serialOut_lsb = reg_q[0];

endmodule
